// File: rtl/ex_stage.sv
// RV32I execute stage: ID/EX register, ALU, branch-target adder and PC select; 1-cycle D->E latency.
// No stall input, so the register loads every edge unless reset or flushed; SrcAE/SrcBE act combinationally.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [1:0]      ResultSrcD,
  input  logic [1:0]      ImmSrcD,
  input  logic [4:0]      rdD,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCplus4D,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [2:0]      ALUControlE,
  output logic [1:0]      ResultSrcE,
  output logic [4:0]      rdE,
  output logic [4:0]      rs1E,
  output logic [4:0]      rs2E,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCplus4E,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultE,
  output logic            ZeroE,
  output logic            PCSrcE
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [2:0]      alu_ctl;
    logic [1:0]      result_src;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus4;
  } idex_t;

  idex_t idex_d;
  idex_t idex_q;

  // Immediate format is already resolved upstream into ImmExtD.
  logic unused_imm_src;
  assign unused_imm_src = ^ImmSrcD;

  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.reg_write  = RegWriteD;
      idex_d.mem_write  = MemWriteD;
      idex_d.jump       = JumpD;
      idex_d.branch     = BranchD;
      idex_d.alu_src    = ALUSrcD;
      idex_d.alu_ctl    = ALUControlD;
      idex_d.result_src = ResultSrcD;
      idex_d.rd         = rdD;
      idex_d.rs1        = rs1D;
      idex_d.rs2        = rs2D;
      idex_d.rd1        = RD1D;
      idex_d.rd2        = RD2D;
      idex_d.pc         = PCD;
      idex_d.imm        = ImmExtD;
      idex_d.pc_plus4   = PCplus4D;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign ALUControlE = idex_q.alu_ctl;
  assign ResultSrcE  = idex_q.result_src;
  assign rdE         = idex_q.rd;
  assign rs1E        = idex_q.rs1;
  assign rs2E        = idex_q.rs2;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign PCE         = idex_q.pc;
  assign ImmExtE     = idex_q.imm;
  assign PCplus4E    = idex_q.pc_plus4;

  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;

  always_comb begin
    alu_b   = idex_q.alu_src ? idex_q.imm : SrcBE;
    alu_res = '0;
    case (idex_q.alu_ctl)
      3'b000: alu_res = SrcAE + alu_b;
      3'b001: alu_res = SrcAE << alu_b[4:0];
      3'b010: alu_res = SrcAE - alu_b;
      3'b011: alu_res = {{(XLEN-1){1'b0}}, ($signed(SrcAE) < $signed(alu_b))};
      3'b100: alu_res = SrcAE & alu_b;
      3'b101: alu_res = SrcAE | alu_b;
      3'b110: alu_res = SrcAE ^ alu_b;
      3'b111: alu_res = SrcAE >> alu_b[4:0];
      default: alu_res = '0;
    endcase
  end

  assign ALUResultE = alu_res;
  assign ZeroE      = (alu_res == '0);
  assign PCTargetE  = idex_q.pc + idex_q.imm;
  assign PCSrcE     = idex_q.jump | (idex_q.branch & ZeroE);

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected E-stage state queued at drive time, popped after each edge or operand change.
module tb_ex_stage;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [2:0]  alu_ctl;
    logic [1:0]  result_src;
    logic [1:0]  imm_src;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
  } d_t;

  typedef struct packed {
    d_t          r;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] target;
    logic        pcsrc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic FlushE = 1'b0;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  d_t dv = '0;
  d_t reg_model = '0;

  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ZeroE, PCSrcE;
  logic [2:0] ALUControlE;
  logic [1:0] ResultSrcE;
  logic [4:0] rdE, rs1E, rs2E;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCplus4E, PCTargetE, ALUResultE;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .FlushE(FlushE),
    .RegWriteD(dv.reg_write), .MemWriteD(dv.mem_write), .JumpD(dv.jump),
    .BranchD(dv.branch), .ALUSrcD(dv.alu_src), .ALUControlD(dv.alu_ctl),
    .ResultSrcD(dv.result_src), .ImmSrcD(dv.imm_src),
    .rdD(dv.rd), .rs1D(dv.rs1), .rs2D(dv.rs2),
    .RD1D(dv.rd1), .RD2D(dv.rd2), .PCD(dv.pc), .ImmExtD(dv.imm), .PCplus4D(dv.pc_plus4),
    .SrcAE(SrcAE), .SrcBE(SrcBE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE),
    .rdE(rdE), .rs1E(rs1E), .rs2E(rs2E),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCplus4E(PCplus4E),
    .PCTargetE(PCTargetE), .ALUResultE(ALUResultE), .ZeroE(ZeroE), .PCSrcE(PCSrcE)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input d_t r, input logic [31:0] a, input logic [31:0] bfwd);
    exp_t e;
    logic [31:0] b;
    e   = '0;
    e.r = r;
    b   = r.alu_src ? r.imm : bfwd;
    case (r.alu_ctl)
      3'd0: e.alu = a + b;
      3'd1: e.alu = a << b[4:0];
      3'd2: e.alu = a - b;
      3'd3: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: e.alu = a & b;
      3'd5: e.alu = a | b;
      3'd6: e.alu = a ^ b;
      default: e.alu = a >> b[4:0];
    endcase
    e.zero   = (e.alu == 32'd0);
    e.target = r.pc + r.imm;
    e.pcsrc  = r.jump | (r.branch & e.zero);
    return e;
  endfunction

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("RegWriteE", {31'd0, RegWriteE}, {31'd0, e.r.reg_write});
    chk("MemWriteE", {31'd0, MemWriteE}, {31'd0, e.r.mem_write});
    chk("JumpE", {31'd0, JumpE}, {31'd0, e.r.jump});
    chk("BranchE", {31'd0, BranchE}, {31'd0, e.r.branch});
    chk("ALUSrcE", {31'd0, ALUSrcE}, {31'd0, e.r.alu_src});
    chk("ALUControlE", {29'd0, ALUControlE}, {29'd0, e.r.alu_ctl});
    chk("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, e.r.result_src});
    chk("rdE", {27'd0, rdE}, {27'd0, e.r.rd});
    chk("rs1E", {27'd0, rs1E}, {27'd0, e.r.rs1});
    chk("rs2E", {27'd0, rs2E}, {27'd0, e.r.rs2});
    chk("RD1E", RD1E, e.r.rd1);
    chk("RD2E", RD2E, e.r.rd2);
    chk("PCE", PCE, e.r.pc);
    chk("ImmExtE", ImmExtE, e.r.imm);
    chk("PCplus4E", PCplus4E, e.r.pc_plus4);
    chk("ALUResultE", ALUResultE, e.alu);
    chk("ZeroE", {31'd0, ZeroE}, {31'd0, e.zero});
    chk("PCTargetE", PCTargetE, e.target);
    chk("PCSrcE", {31'd0, PCSrcE}, {31'd0, e.pcsrc});
  endtask

  // One clock edge with the given reset/flush levels; inputs change #1 after the edge.
  task automatic step(input logic rst_n, input logic flush);
    d_t nxt;
    reset  = rst_n;
    FlushE = flush;
    nxt = dv;
    nxt.imm_src = '0;
    if (!rst_n || flush) nxt = '0;
    reg_model = nxt;
    sb.push_back(model(reg_model, SrcAE, SrcBE));
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  // Operand change with no clock edge.
  task automatic comb_check();
    sb.push_back(model(reg_model, SrcAE, SrcBE));
    #1;
    compare_pop();
  endtask

  function automatic d_t rand_d();
    d_t d;
    d.reg_write  = 1'($urandom);
    d.mem_write  = 1'($urandom);
    d.jump       = ($urandom_range(0, 3) == 0);
    d.branch     = 1'($urandom);
    d.alu_src    = 1'($urandom);
    d.alu_ctl    = 3'($urandom);
    d.result_src = 2'($urandom);
    d.imm_src    = 2'($urandom);
    d.rd         = 5'($urandom);
    d.rs1        = 5'($urandom);
    d.rs2        = 5'($urandom);
    d.rd1        = $urandom;
    d.rd2        = $urandom;
    d.pc         = $urandom;
    d.imm        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    d.pc_plus4   = $urandom;
    return d;
  endfunction

  initial begin
    // Reset with every D field nonzero
    dv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 2'd3, 2'd3, 5'd31, 5'd17, 5'd9,
           32'hDEADBEEF, 32'hCAFEF00D, 32'h00001000, 32'h00000040, 32'h00001004};
    SrcAE = 32'h10; SrcBE = 32'h20;
    step(1'b0, 1'b0);
    chk("rst_alu_add", ALUResultE, 32'h30);
    chk("rst_pcsrc", {31'd0, PCSrcE}, 32'd0);

    // SUB, no branch
    dv.alu_ctl = 3'b010; dv.alu_src = 1'b0; dv.branch = 1'b0; dv.jump = 1'b0;
    SrcAE = 32'h10; SrcBE = 32'h05;
    step(1'b1, 1'b0);
    chk("sub_alu", ALUResultE, 32'h0B);
    chk("sub_pcsrc", {31'd0, PCSrcE}, 32'd0);

    // Taken branch, then operand change without a clock edge
    dv.branch = 1'b1; dv.pc = 32'h00400000; dv.imm = 32'd4;
    SrcAE = 32'h20; SrcBE = 32'h20;
    step(1'b1, 1'b0);
    chk("br_target", PCTargetE, 32'h00400004);
    chk("br_pcsrc", {31'd0, PCSrcE}, 32'd1);
    SrcBE = 32'h21;
    comb_check();
    chk("br_comb_pcsrc", {31'd0, PCSrcE}, 32'd0);

    // Immediate operand with jump
    dv.alu_src = 1'b1; dv.alu_ctl = 3'b000; dv.imm = 32'd4; dv.jump = 1'b1; dv.branch = 1'b0;
    SrcAE = 32'h10;
    step(1'b1, 1'b0);
    chk("jmp_alu", ALUResultE, 32'h14);
    chk("jmp_pcsrc", {31'd0, PCSrcE}, 32'd1);

    // Flush bubble, then reload
    dv.reg_write = 1'b1; dv.mem_write = 1'b1; dv.jump = 1'b1;
    step(1'b1, 1'b1);
    chk("flush_pcsrc", {31'd0, PCSrcE}, 32'd0);
    step(1'b1, 1'b0);
    chk("reload_jump", {31'd0, JumpE}, 32'd1);

    // AND / OR / SLT
    dv.jump = 1'b0; dv.branch = 1'b0; dv.alu_src = 1'b0; dv.alu_ctl = 3'b100;
    SrcAE = 32'h20; SrcBE = 32'h10;
    step(1'b1, 1'b0);
    chk("and_zero", {31'd0, ZeroE}, 32'd1);
    dv.alu_ctl = 3'b101;
    step(1'b1, 1'b0);
    chk("or_alu", ALUResultE, 32'h30);
    dv.alu_ctl = 3'b011; SrcAE = 32'hFFFFFFFF; SrcBE = 32'd1;
    step(1'b1, 1'b0);
    chk("slt_alu", ALUResultE, 32'd1);

    // Reset wins over flush
    step(1'b0, 1'b1);
    chk("rst_over_flush_regw", {31'd0, RegWriteE}, 32'd0);

    // Random traffic, including occasional flush/reset and same-cycle operand changes
    for (int i = 0; i < 60; i++) begin
      dv = rand_d();
      SrcAE = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      SrcBE = ($urandom_range(0, 2) == 0) ? SrcAE : $urandom;
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0));
      SrcBE = ($urandom_range(0, 1) == 0) ? SrcAE : $urandom;
      comb_check();
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
